// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - per-frame peak power bin finder behind the 16-point FFT
// Optional build macro: PEAK_SKIP_DC_EN excludes bin 0 from the peak search.
module fft_peak_detect #(
    parameter int W    = 16,
    parameter int NBIN = 16,
    parameter int BPC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fft_valid,
    input  logic             fft_done,
    input  logic [W-1:0]     fft_d0,
    input  logic [W-1:0]     fft_d1,
    input  logic [W-1:0]     fft_d2,
    input  logic [W-1:0]     fft_d3,
    input  logic [W-1:0]     fft_d4,
    input  logic [W-1:0]     fft_d5,
    input  logic [W-1:0]     fft_d6,
    input  logic [W-1:0]     fft_d7,
    input  logic [W-1:0]     fft_d8,
    input  logic [W-1:0]     fft_d9,
    input  logic [W-1:0]     fft_d10,
    input  logic [W-1:0]     fft_d11,
    input  logic [W-1:0]     fft_d12,
    input  logic [W-1:0]     fft_d13,
    input  logic [W-1:0]     fft_d14,
    input  logic [W-1:0]     fft_d15,
    output logic             peak_valid,
    output logic [3:0]       peak_bin,
    output logic [2*W-1:0]   peak_pwr,
    output logic [5:0]       frame_idx,
    output logic             ovf,
    output logic             done
);

    localparam int SCAN_LEN = NBIN / BPC;

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    state_t              state;
    logic                phase;       // 0 = next valid cycle is real, 1 = imag
    logic                frame_rdy;
    logic [5:0]          cap_idx;
    logic [5:0]          rdy_idx;
    logic [5:0]          scan_idx;
    logic [2:0]          scan_cnt;
    logic [2*W-1:0]      max_pwr;
    logic [3:0]          max_bin;
    logic signed [W-1:0] lane   [NBIN];
    logic signed [W-1:0] re_cap [NBIN];
    logic signed [W-1:0] im_cap [NBIN];
    logic signed [W-1:0] scan_re[NBIN];
    logic signed [W-1:0] scan_im[NBIN];
    logic [3:0]          idx_a;
    logic [3:0]          idx_b;
    logic [2*W-1:0]      pwr_a;
    logic [2*W-1:0]      pwr_b;
    logic [2*W-1:0]      cand_pwr;
    logic [3:0]          cand_bin;
    logic                can_accept;

    assign lane[0]  = fft_d0;
    assign lane[1]  = fft_d1;
    assign lane[2]  = fft_d2;
    assign lane[3]  = fft_d3;
    assign lane[4]  = fft_d4;
    assign lane[5]  = fft_d5;
    assign lane[6]  = fft_d6;
    assign lane[7]  = fft_d7;
    assign lane[8]  = fft_d8;
    assign lane[9]  = fft_d9;
    assign lane[10] = fft_d10;
    assign lane[11] = fft_d11;
    assign lane[12] = fft_d12;
    assign lane[13] = fft_d13;
    assign lane[14] = fft_d14;
    assign lane[15] = fft_d15;

    // re^2 + im^2; the worst case (both -1.0) is exactly 2^31 and still fits unsigned
    function automatic logic [2*W-1:0] power(input logic signed [W-1:0] re,
                                             input logic signed [W-1:0] im);
        logic signed [2*W-1:0] r2;
        logic signed [2*W-1:0] i2;
        r2 = re * re;
        i2 = im * im;
        return $unsigned(r2) + $unsigned(i2);
    endfunction

    assign idx_a      = {scan_cnt, 1'b0};
    assign idx_b      = {scan_cnt, 1'b1};
    assign pwr_a      = power(scan_re[idx_a], scan_im[idx_a]);
    assign pwr_b      = power(scan_re[idx_b], scan_im[idx_b]);
    assign can_accept = (state == IDLE) || (state == OUT);

    // Fold this cycle's two bins into the running max; strict > keeps the lower bin on ties
    always_comb begin
        cand_pwr = max_pwr;
        cand_bin = max_bin;
        if (scan_cnt == 3'd0) begin
`ifdef PEAK_SKIP_DC_EN
            cand_pwr = pwr_b;
            cand_bin = idx_b;
`else
            cand_pwr = pwr_a;
            cand_bin = idx_a;
            if (pwr_b > cand_pwr) begin
                cand_pwr = pwr_b;
                cand_bin = idx_b;
            end
`endif
        end else begin
            if (pwr_a > cand_pwr) begin
                cand_pwr = pwr_a;
                cand_bin = idx_a;
            end
            if (pwr_b > cand_pwr) begin
                cand_pwr = pwr_b;
                cand_bin = idx_b;
            end
        end
    end

    // Lane capture, frame hand-off, scan FSM and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 1'b0;
            frame_rdy  <= 1'b0;
            cap_idx    <= '0;
            rdy_idx    <= '0;
            scan_idx   <= '0;
            scan_cnt   <= '0;
            max_pwr    <= '0;
            max_bin    <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_pwr   <= '0;
            frame_idx  <= '0;
            ovf        <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < NBIN; i++) begin
                re_cap[i]  <= '0;
                im_cap[i]  <= '0;
                scan_re[i] <= '0;
                scan_im[i] <= '0;
            end
        end else begin
            frame_rdy  <= 1'b0;
            peak_valid <= 1'b0;

            if (fft_valid) begin
                phase <= ~phase;
                if (!phase) begin
                    re_cap <= lane;
                end else begin
                    im_cap    <= lane;
                    frame_rdy <= 1'b1;
                    rdy_idx   <= cap_idx;
                    cap_idx   <= cap_idx + 6'd1;
                end
            end

            // A frame arriving while the scanner is busy is lost; its index is still consumed
            if (frame_rdy && !can_accept) begin
                ovf <= 1'b1;
            end

            case (state)
                IDLE, OUT: begin
                    if (frame_rdy) begin
                        scan_re  <= re_cap;
                        scan_im  <= im_cap;
                        scan_idx <= rdy_idx;
                        scan_cnt <= '0;
                        state    <= SCAN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                SCAN: begin
                    max_pwr  <= cand_pwr;
                    max_bin  <= cand_bin;
                    scan_cnt <= scan_cnt + 3'd1;
                    if (scan_cnt == 3'(SCAN_LEN - 1)) begin
                        state      <= OUT;
                        peak_valid <= 1'b1;
                        peak_bin   <= cand_bin;
                        peak_pwr   <= cand_pwr;
                        frame_idx  <= scan_idx;
                    end
                end
                default: state <= IDLE;
            endcase

            // Nothing pending and the scanner is about to be idle: the stream is finished
            if (fft_done && !phase && !frame_rdy && can_accept) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb/tb_fft_peak_detect.sv - directed self-checking bench for fft_peak_detect
module tb_fft_peak_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fft_valid = 1'b0;
    logic        fft_done = 1'b0;
    logic [15:0] d [16];
    logic        peak_valid;
    logic [3:0]  peak_bin;
    logic [31:0] peak_pwr;
    logic [5:0]  frame_idx;
    logic        ovf;
    logic        done;

    logic [15:0] re_v [16];
    logic [15:0] im_v [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fft_peak_detect dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid), .fft_done(fft_done),
        .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
        .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
        .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
        .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
        .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_pwr(peak_pwr),
        .frame_idx(frame_idx), .ovf(ovf), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 16; i++) begin
            re_v[i] = 16'h0000;
            im_v[i] = 16'h0000;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fft_valid = 1'b0;
        fft_done = 1'b0;
        for (int i = 0; i < 16; i++) d[i] = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Real cycle then imag cycle; returns just after the edge that sampled imag
    task automatic send_frame();
        @(posedge clk); #1;
        fft_valid = 1'b1;
        d = re_v;
        @(posedge clk); #1;
        d = im_v;
        @(posedge clk); #1;
        fft_valid = 1'b0;
        for (int i = 0; i < 16; i++) d[i] = 16'h0000;
    endtask

    task automatic expect_peak(input string tag, input logic [3:0] bin,
                               input logic [31:0] pwr, input logic [5:0] idx);
        int lat;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (peak_valid) break;
        end
        check({tag, " latency"}, lat, 9);
        check({tag, " bin"}, {28'd0, peak_bin}, {28'd0, bin});
        check({tag, " pwr"}, peak_pwr, pwr);
        check({tag, " idx"}, {26'd0, frame_idx}, {26'd0, idx});
        @(posedge clk); #1;
        check({tag, " pulse width"}, {31'd0, peak_valid}, 32'd0);
    endtask

    task automatic count_pulses(input int cycles, output int pulses, output logic [5:0] last_idx);
        pulses = 0;
        last_idx = '0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (peak_valid) begin
                pulses++;
                last_idx = frame_idx;
            end
        end
    endtask

    initial begin
        int pulses;
        logic [5:0] lidx;
        logic prev_pv;

        // Reset and idle
        do_reset();
        check("rst peak_valid", {31'd0, peak_valid}, 32'd0);
        check("rst peak_bin", {28'd0, peak_bin}, 32'd0);
        check("rst peak_pwr", peak_pwr, 32'd0);
        check("rst frame_idx", {26'd0, frame_idx}, 32'd0);
        check("rst ovf", {31'd0, ovf}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        count_pulses(50, pulses, lidx);
        check("idle pulses", pulses, 0);

        // Single frame
        clear_vec();
        re_v[5] = 16'h0300;
        im_v[5] = 16'h0400;
        send_frame();
        expect_peak("single", 4'd5, 32'h0019_0000, 6'd0);

        // Tie resolves to the lower bin, then the extreme value
        do_reset();
        clear_vec();
        re_v[3]  = 16'h0100;
        re_v[12] = 16'h0100;
        send_frame();
        expect_peak("tie", 4'd3, 32'h0001_0000, 6'd0);
        clear_vec();
        re_v[15] = 16'h8000;
        im_v[15] = 16'h8000;
        send_frame();
        expect_peak("extreme", 4'd15, 32'h8000_0000, 6'd1);
        check("extreme hold bin", {28'd0, peak_bin}, 32'd15);

        // Overflow: second frame's imag 4 cycles after the first
        do_reset();
        clear_vec();
        re_v[2] = 16'h0100;
        send_frame();
        @(posedge clk); #1;
        clear_vec();
        re_v[7] = 16'h0200;
        send_frame();
        count_pulses(30, pulses, lidx);
        check("ovf pulses", pulses, 1);
        check("ovf first idx", {26'd0, lidx}, 32'd0);
        check("ovf flag", {31'd0, ovf}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        clear_vec();
        re_v[4] = 16'h0100;
        send_frame();
        expect_peak("after ovf", 4'd4, 32'h0001_0000, 6'd2);
        check("ovf sticky", {31'd0, ovf}, 32'd1);

        // DC bin handling
        do_reset();
        clear_vec();
        re_v[0] = 16'h7FFF;
        re_v[9] = 16'h0200;
        send_frame();
`ifdef PEAK_SKIP_DC_EN
        expect_peak("dc skip", 4'd9, 32'h0004_0000, 6'd0);
`else
        expect_peak("dc", 4'd0, 32'h3FFF_0001, 6'd0);
`endif

        // Reset in the middle of a scan discards the result
        do_reset();
        clear_vec();
        re_v[6] = 16'h0100;
        send_frame();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        count_pulses(20, pulses, lidx);
        check("midscan rst pulses", pulses, 0);
        send_frame();
        expect_peak("post rst", 4'd6, 32'h0001_0000, 6'd0);

        // Full stream of 64 frames, then end of stream
        do_reset();
        pulses = 0;
        prev_pv = 1'b0;
        for (int k = 0; k < 64; k++) begin
            clear_vec();
            re_v[k % 16] = 16'h0100;
            send_frame();
            if (k == 63) fft_done = 1'b1;
            for (int j = 0; j < 13; j++) begin
                @(posedge clk); #1;
                if (prev_pv && k == 63) check("done rise", {31'd0, done}, 32'd1);
                if (peak_valid) begin
                    pulses++;
                    check("stream idx", {26'd0, frame_idx}, k);
                    check("stream bin", {28'd0, peak_bin}, k % 16);
                    check("stream done early", {31'd0, done}, 32'd0);
                end
                prev_pv = peak_valid;
            end
        end
        check("stream pulses", pulses, 64);
        check("stream ovf", {31'd0, ovf}, 32'd0);
        check("stream done", {31'd0, done}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
